// File: rtl/keycode_pkg.sv
// Shared constants, FSM state type and named HID usage codes for the keycode report builder.
// Used by both the default build and the KEYCODE_ROLLOVER_EN build.
package keycode_pkg;

    localparam logic [7:0]  KEY_NONE      = 8'h00;
    localparam logic [7:0]  KEY_ROLLOVER  = 8'h01;
    localparam int          NUM_SLOTS     = 4;
    localparam logic [31:0] ROLLOVER_WORD = 32'h0101_0101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_KP0   = 8'h62;
    localparam logic [7:0] KEY_R     = 8'h15;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;

endpackage

// File: rtl/keycode_slot_match.sv
// Combinational 4-way compare of a code against the occupied slots of the key table.
// Reports whether the code is held and the lowest slot index holding it.
module keycode_slot_match
    import keycode_pkg::*;
(
    input  logic [31:0] i_slots,
    input  logic [2:0]  i_count,
    input  logic [7:0]  i_code,
    output logic        o_hit,
    output logic [1:0]  o_idx
);

    // Walk from the top slot down so the lowest matching index wins.
    always_comb begin
        o_hit = 1'b0;
        o_idx = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if ((i_count > 3'(i)) && (i_slots[i*8 +: 8] == i_code)) begin
                o_hit = 1'b1;
                o_idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/keycode_report_builder.sv
// Builds the packed four-slot keycode word from single-key press/release events.
// Optional macro KEYCODE_ROLLOVER_EN adds HID ErrorRollOver reporting on overflow.
module keycode_report_builder
    import keycode_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic        ev_press,
    input  logic [7:0]  ev_code,
    output logic [31:0] keycode,
    output logic        report_valid,
    output logic [2:0]  key_count,
    output logic [1:0]  o_dbg_state
);

    // Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
    // ev_ready is high only in IDLE and never while Reset is asserted.

    state_t      r_state;
    state_t      w_next_state;
    logic        w_xfer;

    logic        r_press;
    logic [7:0]  r_code;
    logic        r_hit;
    logic [1:0]  r_idx;
    logic        w_hit;
    logic [1:0]  w_idx;

    logic [31:0] r_table;
    logic [2:0]  r_count;
    logic [31:0] w_table_ins;
    logic [31:0] w_table_shift;
    logic [39:0] w_table_ext;
    logic        w_full;
    logic        w_do_insert;
    logic        w_do_remove;

    logic [31:0] w_vis_keycode;
    logic [2:0]  w_vis_count;
    logic [31:0] r_keycode;
    logic [2:0]  r_key_count;
    logic        r_report_valid;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_xfer) w_next_state = ST_SEARCH;
            ST_SEARCH: w_next_state = ST_UPDATE;
            ST_UPDATE: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ev_ready    = (r_state == ST_IDLE) && !Reset;
        o_dbg_state = r_state;
    end

    assign w_xfer = ev_valid && ev_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_press <= 1'b0;
            r_code  <= KEY_NONE;
            r_hit   <= 1'b0;
            r_idx   <= 2'd0;
        end else begin
            if (w_xfer) begin
                r_press <= ev_press;
                r_code  <= ev_code;
            end
            if (r_state == ST_SEARCH) begin
                r_hit <= w_hit;
                r_idx <= w_idx;
            end
        end
    end

    keycode_slot_match u_match (
        .i_slots (r_table),
        .i_count (r_count),
        .i_code  (r_code),
        .o_hit   (w_hit),
        .o_idx   (w_idx)
    );

    // Release closes the gap: every slot at or above the hit moves down one.
    assign w_table_ext = {KEY_NONE, r_table};
    always_comb begin
        w_table_shift = r_table;
        w_table_ins   = r_table;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (j >= int'(r_idx)) w_table_shift[j*8 +: 8] = w_table_ext[(j+1)*8 +: 8];
            if (r_count == 3'(j)) w_table_ins[j*8 +: 8] = r_code;
        end
    end

    assign w_full      = (r_count == 3'(NUM_SLOTS));
`ifdef KEYCODE_ROLLOVER_EN
    assign w_do_insert = (r_state == ST_UPDATE) && r_press && !r_hit && !w_full
                         && (r_code != KEY_NONE) && (r_code != KEY_ROLLOVER);
`else
    assign w_do_insert = (r_state == ST_UPDATE) && r_press && !r_hit && !w_full
                         && (r_code != KEY_NONE);
`endif
    assign w_do_remove = (r_state == ST_UPDATE) && !r_press && r_hit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_table <= '0;
            r_count <= 3'd0;
        end else if (w_do_insert) begin
            r_table <= w_table_ins;
            r_count <= r_count + 3'd1;
        end else if (w_do_remove) begin
            r_table <= w_table_shift;
            r_count <= r_count - 3'd1;
        end
    end

`ifdef KEYCODE_ROLLOVER_EN
    logic [2:0] r_ovf_cnt;
    logic       w_ovf_inc;
    logic       w_ovf_dec;

    // Overflow counts presses that found no room; unmatched releases pay them back.
    assign w_ovf_inc = (r_state == ST_UPDATE) && r_press && !r_hit && w_full
                       && (r_code != KEY_NONE) && (r_code != KEY_ROLLOVER)
                       && (r_ovf_cnt != 3'd7);
    assign w_ovf_dec = (r_state == ST_UPDATE) && !r_press && !r_hit
                       && (r_code != KEY_NONE) && (r_ovf_cnt != 3'd0);

    always_ff @(posedge Clk) begin
        if (Reset)          r_ovf_cnt <= 3'd0;
        else if (w_ovf_inc) r_ovf_cnt <= r_ovf_cnt + 3'd1;
        else if (w_ovf_dec) r_ovf_cnt <= r_ovf_cnt - 3'd1;
    end

    assign w_vis_keycode = (r_ovf_cnt != 3'd0) ? ROLLOVER_WORD : r_table;
    assign w_vis_count   = (r_ovf_cnt != 3'd0) ? 3'(NUM_SLOTS) : r_count;
`else
    assign w_vis_keycode = r_table;
    assign w_vis_count   = r_count;
`endif

    // The output stage trails the table by one cycle and pulses on any visible change.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_keycode      <= '0;
            r_key_count    <= 3'd0;
            r_report_valid <= 1'b0;
        end else begin
            r_keycode      <= w_vis_keycode;
            r_key_count    <= w_vis_count;
            r_report_valid <= (w_vis_keycode != r_keycode);
        end
    end

    assign keycode      = r_keycode;
    assign key_count    = r_key_count;
    assign report_valid = r_report_valid;

endmodule
